// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default payload width.
package spi_pkg;

  localparam int SPI_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } spi_state_e;

  // Number of bits a frame carries, including the optional trailing parity bit.
  function automatic int frame_bits(input int data_w, input bit parity_en);
    return parity_en ? data_w + 1 : data_w;
  endfunction

endpackage

// File: rtl/spi_slave_tx_if.sv
// Bus bundle for the SPI responder transmitter: system-side load handshake, SPI pins and status.
interface spi_slave_tx_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              sclk;
  logic              cs;
  logic              miso;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              abort;

  modport slave (
    input  tx_data, tx_valid, sclk, cs,
    output tx_ready, miso, busy, done, underrun, abort
  );

  modport master (
    output tx_data, tx_valid, sclk, cs,
    input  tx_ready, miso, busy, done, underrun, abort
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a one-flop edge detector.
// RST_VAL sets the idle level so reset release does not produce a false edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 responder transmitter on the system clock; one-entry holding buffer feeds the shifter.
// Define SPI_TX_PARITY_EN to append an even-parity bit after the data bits of every frame.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  spi_slave_tx_if.slave bus
);
  // state    | meaning
  // ST_IDLE  | miso held low, waiting for cs fall
  // ST_SHIFT | presenting bits, one per sclk fall
  // ST_HOLD  | all bits presented, miso low until cs rises

  localparam int CNT_W = $clog2(DATA_W + 2);
`ifdef SPI_TX_PARITY_EN
  localparam int                FRAME_BITS = frame_bits(DATA_W, 1'b1);
  localparam logic [CNT_W-1:0]  DATA_CNT   = CNT_W'(DATA_W);
`else
  localparam int                FRAME_BITS = frame_bits(DATA_W, 1'b0);
`endif
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_BITS);

  logic              w_sclk_fall;
  logic              w_sclk_rise;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic              w_load;

  spi_state_e        r_state;
  logic [DATA_W-1:0] r_buf;
  logic              r_full;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_miso;
  logic              r_done;
  logic              r_underrun;
  logic              r_abort;
`ifdef SPI_TX_PARITY_EN
  logic              r_parity;
`endif

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(bus.sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(bus.cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign w_load = bus.tx_valid & ~r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_full     <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
`ifdef SPI_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            r_state <= ST_SHIFT;
            r_cnt   <= CNT_W'(1);
            if (r_full) begin
              r_miso   <= first_bit(r_buf);
              r_shift  <= advance(r_buf);
              r_full   <= 1'b0;
`ifdef SPI_TX_PARITY_EN
              r_parity <= ^r_buf;
`endif
            end else begin
              // Underrun still runs a full-length frame so the master stays in step.
              r_underrun <= 1'b1;
              r_shift    <= '0;
`ifdef SPI_TX_PARITY_EN
              r_parity   <= 1'b0;
`endif
            end
          end
        end

        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_abort <= 1'b1;
            r_miso  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (w_sclk_fall) begin
            if (r_cnt == LAST_CNT) begin
              r_miso  <= 1'b0;
              r_state <= ST_HOLD;
`ifdef SPI_TX_PARITY_EN
            end else if (r_cnt == DATA_CNT) begin
              r_miso <= r_parity;
              r_cnt  <= r_cnt + 1'b1;
`endif
            end else begin
              r_miso  <= first_bit(r_shift);
              r_shift <= advance(r_shift);
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          r_miso <= 1'b0;
          if (w_cs_rise) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_miso  <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase

      // Only possible while the buffer is empty, so it never collides with the move above.
      if (w_load) begin
        r_buf  <= bus.tx_data;
        r_full <= 1'b1;
      end
    end
  end

  assign bus.tx_ready = ~r_full;
  assign bus.miso     = r_miso;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.underrun = r_underrun;
  assign bus.abort    = r_abort;

endmodule
